bcd_conv_sched: RTL and testbench

//  Shares one sequential 16-bit binary-to-BCD engine between NUM_REQ requesters.
//  - Requesters are measurement channels feeding the display/report path.
//  - A round-robin arbiter picks one request and latches its binary operand.
//  - The engine runs double-dabble, one bit per clock, and returns a 5-digit
//    BCD result tagged with the requester ID over a valid/ready handshake.

---
 rtl/bcd_pkg.sv | 11 +
 rtl/bcd_shift_engine.sv | 33 +++
 rtl/bcd_conv_sched.sv | 94 +++++++++
 tb/tb_bcd_conv_sched.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared widths, FSM state type and double-dabble digit adjust.
package bcd_pkg;
  localparam int BIN_W = 16;
  localparam int DIGITS = 5;
  localparam int BCD_W = 20;
  typedef enum logic [1:0] {IDLE, CONV, DONE} bcd_state_e;
  typedef logic [BCD_W-1:0] bcd_t;
  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n > 4'd4) ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/bcd_shift_engine.sv
// bcd_shift_engine: one-bit-per-step double-dabble shift register with bit counter.
module bcd_shift_engine
  import bcd_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load,
  input  logic             step,
  input  logic [BIN_W-1:0] bin,
  output bcd_t             bcd,
  output logic             last
);
  logic [BCD_W+BIN_W-1:0] sr, adj;
  logic [3:0] cnt;
  always_comb begin
    adj = sr;
    for (int d = 0; d < DIGITS; d++) adj[BIN_W+4*d +: 4] = dd_adj(sr[BIN_W+4*d +: 4]);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr <= '0;
      cnt <= '0;
    end else if (load) begin
      sr <= {{BCD_W{1'b0}}, bin};
      cnt <= '0;
    end else if (step) begin
      sr <= {adj[BCD_W+BIN_W-2:0], 1'b0};
      cnt <= cnt + 4'd1;
    end
  end
  assign bcd = sr[BCD_W+BIN_W-1:BIN_W];
  assign last = cnt == 4'd15;
endmodule

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: round-robin scheduler sharing one binary-to-BCD engine.
// Optional leading-zero blanking output blank_o when BCD_BLANK_EN is defined.
module bcd_conv_sched
  import bcd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*BIN_W-1:0] bin_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic                     busy_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [ID_W-1:0]          id_o,
  output bcd_t                     bcd_o
`ifdef BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]        blank_o
`endif
);
  bcd_state_e state, nxt;
  logic [ID_W-1:0] ptr, id, win, idx;
  logic load, step, last;
  bcd_t bcd;
  // Walk downward so the nearest requester after ptr is the last one written.
  always_comb begin
    win = ptr;
    idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (req_i[idx]) win = idx;
    end
  end
  always_comb begin
    nxt = state;
    load = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: begin
        load = |req_i;
        nxt = (|req_i) ? CONV : IDLE;
      end
      CONV: begin
        step = 1'b1;
        nxt = last ? DONE : CONV;
      end
      DONE: nxt = ready_i ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      ptr <= ID_W'(NUM_REQ - 1);
      id <= '0;
    end else begin
      state <= nxt;
      if (load) begin
        ptr <= win;
        id <= win;
      end
    end
  end
  bcd_shift_engine u_engine (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .load  (load),
    .step  (step),
    .bin   (bin_i[BIN_W*win +: BIN_W]),
    .bcd   (bcd),
    .last  (last)
  );
  assign gnt_o = (load && rst_ni) ? NUM_REQ'(1) << win : '0;
  assign busy_o = state != IDLE;
  assign valid_o = state == DONE;
  assign id_o = id;
  assign bcd_o = bcd;
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank;
  logic lead;
  always_comb begin
    blank = '0;
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead = lead && (bcd[4*i +: 4] == 4'd0);
      blank[i] = lead;
    end
  end
  assign blank_o = valid_o ? blank : '0;
`endif
endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb_bcd_conv_sched: directed vectors for the shared BCD converter scheduler.
module tb_bcd_conv_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [63:0] bin = '0;
  logic [3:0] gnt;
  logic busy, valid;
  logic ready = 1'b1;
  logic [1:0] id;
  logic [19:0] bcd;
`ifdef BCD_BLANK_EN
  logic [4:0] blank;
`endif
  int n_chk = 0;
  int n_pass = 0;

  bcd_conv_sched #(.NUM_REQ(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_i  (req),
    .bin_i  (bin),
    .gnt_o  (gnt),
    .busy_o (busy),
    .valid_o(valid),
    .ready_i(ready),
    .id_o   (id),
    .bcd_o  (bcd)
`ifdef BCD_BLANK_EN
    ,
    .blank_o(blank)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_gnt(input logic [3:0] exp);
    int t = 0;
    #1;
    while (gnt == '0 && t < 60) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("gnt", gnt, exp);
  endtask

  task automatic wait_valid(input int first);
    int n = first;
    while (!valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 17);
  endtask

  task automatic run_one(input int ch, input logic [15:0] val, input logic [19:0] exp, input logic [4:0] eb);
    bin[16*ch +: 16] = val;
    req = 4'(1 << ch);
    ready = 1'b1;
    wait_gnt(4'(1 << ch));
    @(negedge clk);
    req = '0;
    wait_valid(1);
    chk("bcd", bcd, exp);
    chk("id", id, ch);
`ifdef BCD_BLANK_EN
    chk("blank", blank, eb);
`else
    if (eb === 5'bx) $display("unused blank vector");
`endif
    @(negedge clk);
    chk("valid_drop", valid, 0);
  endtask

  initial begin
    logic [19:0] rr_exp [4];
    rr_exp[0] = 20'h00001;
    rr_exp[1] = 20'h00022;
    rr_exp[2] = 20'h00333;
    rr_exp[3] = 20'h04444;
    do_reset();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_id", id, 0);
    chk("rst_bcd", bcd, 0);

    run_one(0, 16'd12345, 20'h12345, 5'b00000);
    run_one(1, 16'd0, 20'h00000, 5'b11110);
    run_one(2, 16'd65535, 20'h65535, 5'b00000);
    run_one(3, 16'd9999, 20'h09999, 5'b10000);
    run_one(1, 16'd42, 20'h00042, 5'b11100);
    run_one(0, 16'd10000, 20'h10000, 5'b00000);

    do_reset();
    bin = {16'd4444, 16'd333, 16'd22, 16'd1};
    req = 4'hF;
    ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(4'(1 << (k % 4)));
      wait_valid(0);
      chk("rr_id", id, k % 4);
      chk("rr_bcd", bcd, rr_exp[k % 4]);
      if (k == 4) req = '0;
    end
    @(negedge clk);

    ready = 1'b0;
    bin[47:32] = 16'd54321;
    req = 4'b0100;
    wait_gnt(4'b0100);
    @(negedge clk);
    req = 4'b1011;
    wait_valid(1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", valid, 1);
      chk("bp_bcd", bcd, 20'h54321);
      chk("bp_id", id, 2);
      chk("bp_gnt", gnt, 0);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("bp_idle", busy, 0);
    chk("bp_vdrop", valid, 0);
    #1;
    chk("bp_next_gnt", gnt, 4'b1000);

    do_reset();
    bin[63:48] = 16'd777;
    req = 4'b1000;
    wait_gnt(4'b1000);
    @(negedge clk);
    req = '0;
    repeat (7) @(negedge clk);
    chk("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    bin[31:16] = 16'd500;
    req = 4'b1010;
    #1;
    chk("ar_valid", valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_gnt", gnt, 0);
    chk("ar_id", id, 0);
    chk("ar_bcd", bcd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_next_gnt", gnt, 4'b0010);
    @(negedge clk);
    req = '0;
    wait_valid(1);
    chk("ar_id2", id, 1);
    chk("ar_bcd2", bcd, 20'h00500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
